// File: rtl/id_stage_ctrl.sv
// rtl/id_stage_ctrl.sv - ID-stage hazard, branch-resolve and IF/ID register control
// Optional perf counters: define ID_CTRL_PERF_CNT_EN to add stall_cnt / flush_cnt outputs.
module id_stage_ctrl #(
    parameter int ad_size = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [31:0]        if_instr,
    input  logic [ad_size-1:0] if_pc,
    input  logic               ex_mem_read,
    input  logic               ex_reg_write,
    input  logic [4:0]         ex_dst,
    input  logic               mem_mem_read,
    input  logic [4:0]         mem_dst,
    input  logic [31:0]        rs_val,
    input  logic [31:0]        rt_val,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               id_bubble,
    output logic               if_flush,
    output logic               br_taken,
    output logic [ad_size-1:0] br_target,
    output logic [31:0]        id_instr,
    output logic [ad_size-1:0] id_pc,
    output logic               id_valid
`ifdef ID_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]        id_instr_q, id_instr_d;
    logic [ad_size-1:0] id_pc_q, id_pc_d;
    logic               id_valid_q, id_valid_d;

    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic        uses_rt, is_br;
    logic        ex_match, mem_match;
    logic        lu_haz, br_haz, stall;
    logic        cond, taken;
    logic [ad_size-1:0] br_off;

    assign op  = id_instr_q[31:26];
    assign rs  = id_instr_q[25:21];
    assign rt  = id_instr_q[20:16];
    assign imm = id_instr_q[15:0];

    assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    assign is_br   = (op == OP_BEQ) || (op == OP_BNE);

    // $0 is hard-wired, so a zero destination never matches anything.
    assign ex_match  = (ex_dst  != 5'd0) && ((ex_dst  == rs) || (uses_rt && (ex_dst  == rt)));
    assign mem_match = (mem_dst != 5'd0) && ((mem_dst == rs) || (uses_rt && (mem_dst == rt)));

    assign lu_haz = id_valid_q && ex_mem_read && ex_match;
    assign br_haz = id_valid_q && is_br &&
                    ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
    assign stall  = lu_haz || br_haz;

    assign cond   = (op == OP_BEQ) ? (rs_val == rt_val) : (rs_val != rt_val);
    assign taken  = id_valid_q && is_br && !stall && cond;
    assign br_off = {{(ad_size-18){imm[15]}}, imm, 2'b00};

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        id_bubble  = 1'b0;
        if_flush   = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;
        id_instr_d = if_instr;
        id_pc_d    = if_pc;
        id_valid_d = if_valid;
        state_d    = S_RUN;

        if (id_valid_q) begin
            br_target = id_pc_q + br_off;
        end

        if (stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            id_bubble  = 1'b1;
            id_instr_d = id_instr_q;
            id_pc_d    = id_pc_q;
            id_valid_d = id_valid_q;
        end else if (taken) begin
            if_flush   = 1'b1;
            br_taken   = 1'b1;
            id_instr_d = '0;
            id_pc_d    = '0;
            id_valid_d = 1'b0;
        end

        case (state_q)
            S_RUN, S_STALL: begin
                if (taken) begin
                    state_d = S_FLUSH;
                end else if (stall) begin
                    state_d = S_STALL;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            id_instr_q <= '0;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;
    assign id_valid = id_valid_q;

    // A flushed slot is always empty, so FLUSH can never see a hazard or branch.
    a_flush_empty: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_FLUSH) |-> !id_valid_q);

`ifdef ID_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (if_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb/tb_id_stage_ctrl.sv - directed self-checking bench for id_stage_ctrl
module tb_id_stage_ctrl;

    localparam logic [31:0] I_ADD  = 32'h010A_4820; // add  $9,$8,$10
    localparam logic [31:0] I_ADDI = 32'h2005_0001; // addi $5,$0,1
    localparam logic [31:0] I_SW   = 32'hAD28_0000; // sw   $8,0($9)
    localparam logic [31:0] I_LW   = 32'h8D28_0000; // lw   $8,0($9)
    localparam logic [31:0] I_BEQ8 = 32'h1100_0004; // beq  $8,$0,+4
    localparam logic [31:0] I_BEQT = 32'h1022_FFFC; // beq  $1,$2,-4
    localparam logic [31:0] I_BNE  = 32'h1464_0010; // bne  $3,$4,+16

    logic        clk, rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        ex_mem_read, ex_reg_write;
    logic [4:0]  ex_dst;
    logic        mem_mem_read;
    logic [4:0]  mem_dst;
    logic [31:0] rs_val, rt_val;
    logic        pc_write, ifid_write, id_bubble, if_flush, br_taken;
    logic [31:0] br_target;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
`ifdef ID_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    id_stage_ctrl #(.ad_size(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_dst       (ex_dst),
        .mem_mem_read (mem_mem_read),
        .mem_dst      (mem_dst),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .id_bubble    (id_bubble),
        .if_flush     (if_flush),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_valid     (id_valid)
`ifdef ID_CTRL_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b1; if_instr = I_ADD; if_pc = 32'h104;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = 5'd0;
        mem_mem_read = 1'b0; mem_dst = 5'd0; rs_val = 32'd0; rt_val = 32'd0;

        // reset held two cycles with a valid fetch
        step(); step();
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_ifid_write", ifid_write, 1);
        chk("rst_bubble", id_bubble, 0);
        chk("rst_flush", if_flush, 0);
        chk("rst_br_taken", br_taken, 0);
        chk("rst_br_target", br_target, 0);
        chk("rst_fsm", 64'(dut.state_q), 0);

        rst = 1'b0;
        step();
        chk("load_instr", id_instr, I_ADD);
        chk("load_pc", id_pc, 32'h104);
        chk("load_valid", id_valid, 1);

        // load-use: lw $8 in EX, add uses $8
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd8;
        if_instr = I_ADDI; if_pc = 32'h108;
        #1;
        chk("lu_pc_write", pc_write, 0);
        chk("lu_ifid_write", ifid_write, 0);
        chk("lu_bubble", id_bubble, 1);
        chk("lu_flush", if_flush, 0);
        step();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = 5'd0;
        mem_mem_read = 1'b1; mem_dst = 5'd8;
        #1;
        chk("lu_held", id_instr, I_ADD);
        chk("lu_fsm_stall", 64'(dut.state_q), 1);
        chk("lu_released", pc_write, 1);
        chk("lu_no_bubble", id_bubble, 0);
        step();
        mem_mem_read = 1'b0; mem_dst = 5'd0;
        chk("lu_proceed", id_instr, I_ADDI);
        chk("lu_fsm_run", 64'(dut.state_q), 0);

        // $0 destination and non-rt-user with matching rt
        ex_mem_read = 1'b1; ex_dst = 5'd0;
        #1;
        chk("r0_no_stall", pc_write, 1);
        ex_dst = 5'd5;
        #1;
        chk("addi_rt_no_stall", id_bubble, 0);
        if_instr = I_SW; if_pc = 32'h10C;
        step();
`ifdef ID_CTRL_PERF_CNT_EN
        chk("r0_stall_cnt", stall_cnt, 1);
`endif
        chk("sw_loaded", id_instr, I_SW);
        ex_dst = 5'd8;
        #1;
        chk("sw_rt_stall", id_bubble, 1);
        ex_mem_read = 1'b0;
        #1;
        chk("sw_alu_no_stall", pc_write, 1);
        if_instr = I_LW; if_pc = 32'h110;
        step();
        ex_mem_read = 1'b1; ex_dst = 5'd8;
        #1;
        chk("lw_rt_no_stall", pc_write, 1);
        ex_dst = 5'd9;
        #1;
        chk("lw_rs_stall", pc_write, 0);
        ex_mem_read = 1'b0; ex_dst = 5'd0;

        // branch after load: two stall cycles
        if_instr = I_BEQ8; if_pc = 32'h200;
        step();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd8;
        rs_val = 32'd3; rt_val = 32'd0;
        #1;
        chk("bl_stall1", id_bubble, 1);
        chk("bl_stall1_taken", br_taken, 0);
        step();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = 5'd0;
        mem_mem_read = 1'b1; mem_dst = 5'd8;
        #1;
        chk("bl_stall2", id_bubble, 1);
        chk("bl_fsm_stall", 64'(dut.state_q), 1);
        step();
        mem_mem_read = 1'b0; mem_dst = 5'd0;
        #1;
        chk("bl_resolved", pc_write, 1);
        chk("bl_not_taken", br_taken, 0);
        chk("bl_target", br_target, 32'h210);
        ex_reg_write = 1'b1; ex_dst = 5'd8;
        #1;
        chk("br_alu_stall", id_bubble, 1);
        chk("br_alu_no_take", if_flush, 0);
        ex_reg_write = 1'b0; ex_dst = 5'd0;

        // taken beq with negative offset
        if_instr = I_BEQT; if_pc = 32'h100;
        step();
        chk("bt_fsm_run", 64'(dut.state_q), 0);
        rs_val = 32'd5; rt_val = 32'd5;
        if_instr = I_BNE; if_pc = 32'h100;
        #1;
        chk("bt_target", br_target, 32'h0F0);
        chk("bt_taken", br_taken, 1);
        chk("bt_flush", if_flush, 1);
        chk("bt_pc_write", pc_write, 1);
        step();
        chk("bt_squash_valid", id_valid, 0);
        chk("bt_squash_instr", id_instr, 0);
        chk("bt_fsm_flush", 64'(dut.state_q), 2);
        chk("bt_target_idle", br_target, 0);
        chk("bt_taken_idle", br_taken, 0);

        // not-taken bne, then taken bne
        step();
        chk("bne_loaded", id_instr, I_BNE);
        chk("bne_fsm_run", 64'(dut.state_q), 0);
        rs_val = 32'd7; rt_val = 32'd7;
        #1;
        chk("bne_target", br_target, 32'h140);
        chk("bne_not_taken", br_taken, 0);
        chk("bne_no_flush", if_flush, 0);
        chk("bne_no_stall", pc_write, 1);
        rs_val = 32'd8;
        #1;
        chk("bne_taken", br_taken, 1);
        step();
`ifdef ID_CTRL_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, 3);
        chk("flush_cnt", flush_cnt, 2);
`endif

        // reset in the middle of a stall
        if_instr = I_ADD; if_pc = 32'h300;
        step();
        ex_mem_read = 1'b1; ex_dst = 5'd8;
        step();
        chk("mid_fsm_stall", 64'(dut.state_q), 1);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", id_valid, 0);
        chk("mid_rst_fsm", 64'(dut.state_q), 0);
        chk("mid_rst_pc_write", pc_write, 1);
`ifdef ID_CTRL_PERF_CNT_EN
        chk("mid_rst_cnt", stall_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
